// File: rtl/i2c_pkg.sv
// Shared definitions for the register-level I2C sequencer: engine command
// bits, R/W bit values, the one-hot controller state encoding and small
// helpers describing the byte-step sequence.
package i2c_pkg;

    localparam logic [5:0] CMD_WR   = 6'd1;
    localparam logic [5:0] CMD_STA  = 6'd2;
    localparam logic [5:0] CMD_RD   = 6'd4;
    localparam logic [5:0] CMD_STO  = 6'd8;
    localparam logic [5:0] CMD_ACK  = 6'd16;
    localparam logic [5:0] CMD_NACK = 6'd32;

    localparam logic DEV_RW_W = 1'b0;
    localparam logic DEV_RW_R = 1'b1;

    typedef enum logic [7:0] {
        ST_IDLE   = 8'b0000_0001,
        ST_DEV_W  = 8'b0000_0010,
        ST_REG_H  = 8'b0000_0100,
        ST_REG_L  = 8'b0000_1000,
        ST_WDATA  = 8'b0001_0000,
        ST_DEV_R  = 8'b0010_0000,
        ST_RDATA  = 8'b0100_0000,
        ST_FINISH = 8'b1000_0000
    } state_t;

    // Each byte step first issues the command, then waits for the engine.
    typedef enum logic {
        PH_ISSUE = 1'b0,
        PH_WAIT  = 1'b1
    } phase_t;

    // Step that follows 'cur' once its byte has completed.
    function automatic state_t next_step(input state_t cur, input logic is_wr,
                                         input logic a16);
        state_t nxt;
        case (cur)
            ST_DEV_W: nxt = a16 ? ST_REG_H : ST_REG_L;
            ST_REG_H: nxt = ST_REG_L;
            ST_REG_L: nxt = is_wr ? ST_WDATA : ST_DEV_R;
            ST_WDATA: nxt = ST_FINISH;
            ST_DEV_R: nxt = ST_RDATA;
            ST_RDATA: nxt = ST_FINISH;
            default:  nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    // Engine command and transmit byte for a step, packed as {Cmd, Tx}.
    function automatic logic [13:0] step_cmd(input state_t st, input logic [6:0] dev,
                                             input logic [15:0] ra, input logic [7:0] wd);
        logic [13:0] ct;
        case (st)
            ST_DEV_W: ct = {CMD_STA | CMD_WR, dev, DEV_RW_W};
            ST_REG_H: ct = {CMD_WR, ra[15:8]};
            ST_REG_L: ct = {CMD_WR, ra[7:0]};
            ST_WDATA: ct = {CMD_WR | CMD_STO, wd};
            ST_DEV_R: ct = {CMD_STA | CMD_WR, dev, DEV_RW_R};
            ST_RDATA: ct = {CMD_RD | CMD_NACK | CMD_STO, 8'h00};
            default:  ct = 14'd0;
        endcase
        return ct;
    endfunction

endpackage

// File: rtl/i2c_step_timer.sv
// Per-step watchdog: cleared whenever a Go is issued, counts the cycles spent
// waiting for Trans_Done and flags expiry on the last allowed wait cycle.
module i2c_step_timer #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd65535
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic load,
    input  logic run,
    output logic expire
);

    logic [15:0] cnt_r;

    // Wait-cycle counter, restarted by each Go.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_r <= 16'd0;
        end else if (load) begin
            cnt_r <= 16'd0;
        end else if (run) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expiry lands so that the abort is visible TIMEOUT_CYC cycles after Go.
    assign expire = run && (cnt_r == (TIMEOUT_CYC - 16'd1));

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Register-level I2C sequencer: turns one register write/read request into
// the ordered byte commands for the byte engine and reports the outcome.
module i2c_reg_ctrl
    import i2c_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYC = 16'd65535
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [6:0]  dev_addr,
    input  logic [15:0] reg_addr,
    input  logic        addr16,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        rw_done,
    output logic        ack_err,
    output logic        timeout,
    output logic [5:0]  Cmd,
    output logic        Go,
    output logic [7:0]  Tx_DATA,
    input  logic [7:0]  Rx_DATA,
    input  logic        Trans_Done,
    input  logic        ack_o
);

    state_t      state_r, state_s, step_nxt_s;
    phase_t      phase_r, phase_s;
    logic        op_wr_r, op_wr_s;
    logic        a16_r, a16_s;
    logic [6:0]  dev_r, dev_s;
    logic [15:0] reg_r, reg_s;
    logic [7:0]  wdat_r, wdat_s;
    logic [7:0]  rd_data_s;
    logic        busy_s, rw_done_s, ack_err_s, timeout_s, go_s;
    logic [5:0]  cmd_s;
    logic [7:0]  tx_s;
    logic        timer_run_s, expire_s;

    assign timer_run_s = (phase_r == PH_WAIT) && !Trans_Done;

    i2c_step_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .load   (go_s),
        .run    (timer_run_s),
        .expire (expire_s)
    );

    // Next-state and next-output decode for the byte-step sequencer.
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        op_wr_s    = op_wr_r;
        a16_s      = a16_r;
        dev_s      = dev_r;
        reg_s      = reg_r;
        wdat_s     = wdat_r;
        rd_data_s  = rd_data;
        busy_s     = busy;
        rw_done_s  = 1'b0;
        ack_err_s  = ack_err;
        timeout_s  = timeout;
        go_s       = 1'b0;
        cmd_s      = Cmd;
        tx_s       = Tx_DATA;
        step_nxt_s = next_step(state_r, op_wr_r, a16_r);

        case (state_r)
            ST_IDLE: begin
                // A write request takes priority over a simultaneous read.
                if (wr_req || rd_req) begin
                    op_wr_s   = wr_req;
                    a16_s     = addr16;
                    dev_s     = dev_addr;
                    reg_s     = reg_addr;
                    wdat_s    = wr_data;
                    ack_err_s = 1'b0;
                    timeout_s = 1'b0;
                    busy_s    = 1'b1;
                    state_s   = ST_DEV_W;
                    phase_s   = PH_ISSUE;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_DEV_W, ST_REG_H, ST_REG_L, ST_WDATA, ST_DEV_R, ST_RDATA: begin
                if (phase_r == PH_ISSUE) begin
                    go_s           = 1'b1;
                    {cmd_s, tx_s}  = step_cmd(state_r, dev_r, reg_r, wdat_r);
                    phase_s        = PH_WAIT;
                end else if (Trans_Done) begin
                    // The final read byte is always NACKed by us, so its ack is meaningless.
                    if (state_r == ST_RDATA) begin
                        rd_data_s = Rx_DATA;
                    end else begin
                        ack_err_s = ack_err | ack_o;
                    end
                    state_s = step_nxt_s;
                    phase_s = PH_ISSUE;
                    if (step_nxt_s == ST_FINISH) begin
                        rw_done_s = 1'b1;
                        busy_s    = 1'b0;
                    end else begin
                        busy_s    = 1'b1;
                    end
                end else if (expire_s) begin
                    // Engine stalled: abort without a stop, the owner resets the engine.
                    timeout_s = 1'b1;
                    rw_done_s = 1'b1;
                    busy_s    = 1'b0;
                    state_s   = ST_FINISH;
                    phase_s   = PH_ISSUE;
                end else begin
                    state_s   = state_r;
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
                phase_s = PH_ISSUE;
            end
            default: begin
                state_s = ST_IDLE;
                phase_s = PH_ISSUE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, latched request and registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
            phase_r <= PH_ISSUE;
            op_wr_r <= 1'b0;
            a16_r   <= 1'b0;
            dev_r   <= 7'd0;
            reg_r   <= 16'd0;
            wdat_r  <= 8'd0;
            rd_data <= 8'd0;
            busy    <= 1'b0;
            rw_done <= 1'b0;
            ack_err <= 1'b0;
            timeout <= 1'b0;
            Go      <= 1'b0;
            Cmd     <= 6'd0;
            Tx_DATA <= 8'd0;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            op_wr_r <= op_wr_s;
            a16_r   <= a16_s;
            dev_r   <= dev_s;
            reg_r   <= reg_s;
            wdat_r  <= wdat_s;
            rd_data <= rd_data_s;
            busy    <= busy_s;
            rw_done <= rw_done_s;
            ack_err <= ack_err_s;
            timeout <= timeout_s;
            Go      <= go_s;
            Cmd     <= cmd_s;
            Tx_DATA <= tx_s;
        end
    end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Self-checking bench for i2c_reg_ctrl: a behavioural byte-engine responder
// plus a transaction-level model of the expected command list and results.
module tb_i2c_reg_ctrl;

    localparam logic [15:0] TO_CYC = 16'd100;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        wr_req = 1'b0;
    logic        rd_req = 1'b0;
    logic [6:0]  dev_addr = 7'd0;
    logic [15:0] reg_addr = 16'd0;
    logic        addr16 = 1'b0;
    logic [7:0]  wr_data = 8'd0;
    logic [7:0]  rd_data;
    logic        busy, rw_done, ack_err, timeout, Go;
    logic [5:0]  Cmd;
    logic [7:0]  Tx_DATA;
    logic [7:0]  Rx_DATA = 8'd0;
    logic        Trans_Done = 1'b0;
    logic        ack_o = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [13:0] exp_q[$];
    logic [13:0] got_q[$];

    i2c_reg_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .wr_req(wr_req), .rd_req(rd_req),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .addr16(addr16), .wr_data(wr_data),
        .rd_data(rd_data), .busy(busy), .rw_done(rw_done), .ack_err(ack_err),
        .timeout(timeout), .Cmd(Cmd), .Go(Go), .Tx_DATA(Tx_DATA), .Rx_DATA(Rx_DATA),
        .Trans_Done(Trans_Done), .ack_o(ack_o)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One register transaction. nack_idx: step answered with NACK; hang_idx: step the
    // engine never completes; rst_idx: step during whose wait reset is pulsed.
    task automatic run_txn(input logic do_wr, input logic do_rd, input logic [6:0] dev,
                           input logic [15:0] ra, input logic a16, input logic [7:0] wd,
                           input logic [7:0] rx, input int nack_idx, input int hang_idx,
                           input int rst_idx, input logic poke_rd);
        logic is_wr, done, was_rst, exp_ack, got_ack, got_to, got_busy;
        logic [7:0] got_rd;
        int n_steps, exp_go, k, pend, cur, last_go, td_k, done_k, quiet;

        is_wr = do_wr;
        exp_q.delete();
        got_q.delete();
        exp_q.push_back({6'h03, dev, 1'b0});
        if (a16) exp_q.push_back({6'h01, ra[15:8]});
        exp_q.push_back({6'h01, ra[7:0]});
        if (is_wr) begin
            exp_q.push_back({6'h09, wd});
        end else begin
            exp_q.push_back({6'h03, dev, 1'b1});
            exp_q.push_back({6'h2C, 8'h00});
        end
        n_steps = exp_q.size();
        exp_go  = (hang_idx >= 0) ? hang_idx + 1 : n_steps;
        exp_ack = (nack_idx >= 0) && (nack_idx < n_steps) &&
                  ((hang_idx < 0) || (nack_idx < hang_idx)) &&
                  !(!is_wr && (nack_idx == n_steps - 1));

        @(negedge Clk);
        wr_req = do_wr; rd_req = do_rd;
        dev_addr = dev; reg_addr = ra; addr16 = a16; wr_data = wd;

        k = 0; pend = 0; cur = -1; done = 1'b0; was_rst = 1'b0;
        last_go = 0; td_k = -10; done_k = 0;
        got_ack = 1'b0; got_to = 1'b0; got_busy = 1'b0; got_rd = 8'd0;
        while (!done && k < 1000) begin
            @(negedge Clk);
            if (k == 0) begin
                wr_req = 1'b0;
                check_eq("busy_after_accept", 32'(busy), 32'd1);
                check_eq("ack_err_cleared", 32'(ack_err), 32'd0);
                check_eq("timeout_cleared", 32'(timeout), 32'd0);
                dev_addr = 7'($urandom); reg_addr = 16'($urandom);
                addr16 = 1'($urandom); wr_data = 8'($urandom);
            end
            rd_req = poke_rd && (k == 3);
            Trans_Done = 1'b0;
            ack_o = 1'b0;
            if (Go) begin
                got_q.push_back({Cmd, Tx_DATA});
                cur = got_q.size() - 1;
                if (cur > 0) check_eq("go_gap", 32'(k - td_k >= 2), 32'd1);
                last_go = k;
                pend = (cur == hang_idx) ? 0 : int'($urandom_range(1, 4));
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    Trans_Done = 1'b1;
                    ack_o = (cur == nack_idx);
                    Rx_DATA = (cur == n_steps - 1) ? rx : 8'($urandom);
                    td_k = k;
                end
            end
            if (rw_done) begin
                done = 1'b1; done_k = k;
                got_ack = ack_err; got_to = timeout; got_busy = busy; got_rd = rd_data;
            end
            if (!done && rst_idx >= 0 && cur == rst_idx && k == last_go + 2) begin
                Rst_n = 1'b0;
                #1;
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_go", 32'(Go), 32'd0);
                check_eq("rst_done", 32'(rw_done), 32'd0);
                check_eq("rst_cmd", 32'(Cmd), 32'd0);
                @(negedge Clk);
                Rst_n = 1'b1;
                was_rst = 1'b1;
                done = 1'b1;
            end
            k++;
        end
        Trans_Done = 1'b0; ack_o = 1'b0; rd_req = 1'b0;

        if (!was_rst) begin
            check_eq("rw_done_seen", 32'(done), 32'd1);
            check_eq("go_count", 32'(got_q.size()), 32'(exp_go));
            for (int i = 0; i < exp_go && i < got_q.size(); i++)
                check_eq("step_cmd_tx", 32'(got_q[i]), 32'(exp_q[i]));
            check_eq("ack_err", 32'(got_ack), 32'(exp_ack));
            check_eq("timeout", 32'(got_to), 32'(hang_idx >= 0));
            check_eq("busy_at_done", 32'(got_busy), 32'd0);
            if (hang_idx >= 0)
                check_eq("timeout_latency", 32'(done_k - last_go), 32'(TO_CYC));
            else
                check_eq("done_latency", 32'(done_k - td_k), 32'd1);
            if (!is_wr && hang_idx < 0)
                check_eq("rd_data", 32'(got_rd), 32'(rx));
        end
        quiet = 0;
        repeat (6) begin
            @(negedge Clk);
            if (Go || rw_done) quiet++;
        end
        check_eq("idle_quiet", 32'(quiet), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int mode, nk, hg;
        logic a16r, wr_r, rd_r;
        repeat (3) @(negedge Clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_rw_done", 32'(rw_done), 32'd0);
        check_eq("reset_ack_err", 32'(ack_err), 32'd0);
        check_eq("reset_timeout", 32'(timeout), 32'd0);
        check_eq("reset_go", 32'(Go), 32'd0);
        check_eq("reset_rd_data", 32'(rd_data), 32'd0);
        check_eq("reset_cmd", 32'(Cmd), 32'd0);
        check_eq("reset_tx", 32'(Tx_DATA), 32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Directed cases
        run_txn(1'b1, 1'b0, 7'h3C, 16'h0012, 1'b0, 8'hA5, 8'h00, -1, -1, -1, 1'b0);
        run_txn(1'b0, 1'b1, 7'h21, 16'h300A, 1'b1, 8'h00, 8'h56, -1, -1, -1, 1'b0);
        run_txn(1'b1, 1'b0, 7'h50, 16'h0034, 1'b0, 8'h11, 8'h00,  1, -1, -1, 1'b0);
        run_txn(1'b0, 1'b1, 7'h50, 16'h0077, 1'b0, 8'h00, 8'h9E, -1, -1, -1, 1'b0);
        run_txn(1'b1, 1'b0, 7'h1A, 16'h0001, 1'b0, 8'h22, 8'h00, -1,  0, -1, 1'b0);
        run_txn(1'b1, 1'b1, 7'h2B, 16'hBEEF, 1'b1, 8'hC3, 8'h00, -1, -1, -1, 1'b1);
        run_txn(1'b0, 1'b1, 7'h44, 16'h0055, 1'b0, 8'h00, 8'h00, -1,  2,  2, 1'b0);
        run_txn(1'b1, 1'b0, 7'h44, 16'h0056, 1'b0, 8'h5A, 8'h00, -1, -1, -1, 1'b0);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            mode = int'($urandom_range(0, 3));
            wr_r = (mode == 0) || (mode == 2);
            rd_r = (mode != 0);
            a16r = 1'($urandom);
            nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            hg = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1;
            run_txn(wr_r, rd_r, 7'($urandom), 16'($urandom), a16r, 8'($urandom),
                    8'($urandom), nk, hg, -1, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_reg_ctrl.md
Name: i2c_reg_ctrl

Overview:
- Register-level I2C transaction sequencer. Sits above the byte-level I2C engine, which accepts Cmd/Go/Tx_DATA and returns Rx_DATA/Trans_Done/ack_o.
- Converts one register write or read request into the ordered byte commands:
  - device address
  - 8- or 16-bit register address
  - data byte, or repeated start plus data read
- Reports completion, read data, NACK errors and engine timeout to the user logic, e.g. the sensor init ROM walker.

Parameters:
- TIMEOUT_CYC, 16'd65535: max Clk cycles from Go to Trans_Done before the timeout abort. Width is 16 bits.

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  asynchronous, active-low reset
- wr_req  in  1  single-cycle pulse: start register write
- rd_req  in  1  single-cycle pulse: start register read
- dev_addr  in  7  7-bit slave address
- reg_addr  in  16  register address; only [7:0] is used when addr16=0
- addr16  in  1  1 = 16-bit register address, 0 = 8-bit
- wr_data  in  8  byte to write
- rd_data  out  8  byte read, valid when rw_done=1 after a read
- busy  out  1  transaction in progress
- rw_done  out  1  one-cycle pulse at transaction end
- ack_err  out  1  sticky for the transaction: at least one byte NACKed by the slave
- timeout  out  1  set with rw_done when the engine did not respond in time
- Cmd  out  6  engine command bits: WR=1, STA=2, RD=4, STO=8, ACK=16, NACK=32
- Go  out  1  one-cycle engine start pulse
- Tx_DATA  out  8  byte to the engine
- Rx_DATA  in  8  byte from the engine
- Trans_Done  in  1  one-cycle engine completion pulse
- ack_o  in  1  engine-sampled ACK bit (1 = NACK)

Behaviour:
- Reset values:
  - busy, rw_done, ack_err, timeout, Go = 0
  - rd_data, Cmd, Tx_DATA = 0
  - state = IDLE; timeout counter = 0
- Request acceptance:
  - Accepted only in IDLE.
  - wr_req and rd_req in the same cycle: the write wins and the read is dropped.
  - Requests while busy are ignored, with no queueing.
- On accept:
  - Latch dev_addr, reg_addr, addr16, wr_data and the operation type.
  - Clear ack_err and timeout.
  - busy = 1 from the next cycle.
- Each byte step has two phases:
  - ISSUE: drive Cmd/Tx_DATA and pulse Go for exactly 1 cycle. Cmd and Tx_DATA are held stable until Trans_Done.
  - WAIT: wait for Trans_Done. On Trans_Done, ack_err |= ack_o for write-type steps, then advance.
  - Go is never reasserted in the same cycle as Trans_Done. The next ISSUE comes at least 1 cycle later.
- States and command sequence:
  - IDLE
  - DEV_W: Cmd=STA|WR, Tx={dev_addr,1'b0}
  - REG_H: Cmd=WR, Tx=reg_addr[15:8]. Skipped when addr16=0.
  - REG_L, write operation: Cmd=WR, Tx=reg_addr[7:0]
  - REG_L, read operation: Cmd=WR, Tx=reg_addr[7:0] (no stop)
  - WDATA (write only): Cmd=WR|STO, Tx=wr_data
  - DEV_R (read only): Cmd=STA|WR, Tx={dev_addr,1'b1}. This is a repeated start.
  - RDATA (read only): Cmd=RD|NACK|STO, Tx=0. On Trans_Done, rd_data <= Rx_DATA. ack_o is ignored in this step.
  - FINISH: rw_done=1 for 1 cycle, busy=0 the same cycle, then IDLE.
- NACK handling:
  - The sequence continues to the final STO byte, because the engine has no standalone stop.
  - ack_err is reported with rw_done.
- Timeout:
  - The counter resets at each Go and increments during WAIT.
  - Reaching TIMEOUT_CYC without Trans_Done sets timeout=1, rw_done pulses, and the state returns to IDLE.
  - No stop is issued. User logic is expected to reset the engine.
- Trans_Done outside WAIT is ignored.
- Reset mid-transaction: immediate return to IDLE, all outputs at reset values, with no partial rw_done.
- Latency: rw_done comes 1 cycle after the last Trans_Done.

Decomposition:
- Shared package i2c_pkg holds:
  - the Cmd bit constants WR/STA/RD/STO/ACK/NACK
  - the controller state encoding (one-hot, 8 states plus the ISSUE/WAIT flag)
  - a DEV_RW_W/R bit constant
- One optional sub-module, i2c_step_timer: the timeout counter with load-on-Go and expire outputs.
- The byte engine is instantiated alongside this block by the parent, not inside it.

Test Plan:
1. Write, addr16=0: dev=0x3C, reg=0x12, data=0xA5 → Go ×3 with (Cmd,Tx) = (0x03,0x78), (0x01,0x12), (0x09,0xA5). rw_done pulses once, ack_err=0.
2. Read, addr16=1: dev=0x21, reg=0x300A; engine model returns Rx=0x56 → sequence (0x03,0x42), (0x01,0x30), (0x01,0x0A), (0x03,0x43), (0x2C,0x00). rd_data=0x56 at rw_done.
3. NACK: model returns ack_o=1 on the REG_L step → all remaining steps are still issued, ack_err=1 with rw_done, and ack_err clears on the next accept.
4. Timeout: TIMEOUT_CYC=100, model never returns Trans_Done → timeout=1 and rw_done exactly 100 cycles after Go, then back to IDLE with busy=0.
5. Simultaneous wr_req+rd_req → write performed only. A rd_req during busy is ignored, and exactly one rw_done results.
6. Rst_n asserted during the DEV_R wait → busy/Go/rw_done=0 immediately. After release, a new write completes normally.
